// File: rtl/dmem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_pkg
// Shared definitions for the data-memory arbiter: FSM state encoding, byte
// enable constants and the helper that picks the first state after a grant.
// -----------------------------------------------------------------------------
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_e;

  localparam logic [3:0] BE_FULL = 4'b1111;
  localparam logic [3:0] BE_NONE = 4'b0000;

  // Loads and partial stores need the current word first; full stores go
  // straight to the write; an all-zero enable store touches nothing.
  function automatic state_e first_state(input logic we, input logic [3:0] be);
    if (!we)                return RD;
    else if (be == BE_FULL) return WR;
    else if (be == BE_NONE) return RESP;
    else                    return RD;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
// Bundles both requester ports and the data_memory bus of the arbiter.
//   pX_req/we/addr/wd/be : request and payload from requester X
//   pX_gnt/done/rd       : grant pulse, completion pulse, load data to X
//   mem_A/WD/WE          : address, write data, write enable to data_memory
//   mem_RD               : combinational read data from data_memory
// Modports: master = requesters + memory side, slave = the arbiter.
// -----------------------------------------------------------------------------
interface dmem_arbiter_if #(
  parameter int N = 8,
  parameter int W = 32
);

  logic         p0_req;
  logic         p0_we;
  logic [N-1:0] p0_addr;
  logic [W-1:0] p0_wd;
  logic [3:0]   p0_be;
  logic         p0_gnt;
  logic         p0_done;
  logic [W-1:0] p0_rd;

  logic         p1_req;
  logic         p1_we;
  logic [N-1:0] p1_addr;
  logic [W-1:0] p1_wd;
  logic [3:0]   p1_be;
  logic         p1_gnt;
  logic         p1_done;
  logic [W-1:0] p1_rd;

  logic [N-1:0] mem_A;
  logic [W-1:0] mem_WD;
  logic         mem_WE;
  logic [W-1:0] mem_RD;

  modport master (
    output p0_req, p0_we, p0_addr, p0_wd, p0_be,
    input  p0_gnt, p0_done, p0_rd,
    output p1_req, p1_we, p1_addr, p1_wd, p1_be,
    input  p1_gnt, p1_done, p1_rd,
    input  mem_A, mem_WD, mem_WE,
    output mem_RD
  );

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wd, p0_be,
    output p0_gnt, p0_done, p0_rd,
    input  p1_req, p1_we, p1_addr, p1_wd, p1_be,
    output p1_gnt, p1_done, p1_rd,
    output mem_A, mem_WD, mem_WE,
    input  mem_RD
  );

endinterface

// File: rtl/dmem_arbiter_be_merge.sv
// -----------------------------------------------------------------------------
// be_merge
// Byte-lane merge for sub-word stores: lane i of merged_o comes from new_i
// when be_i[i] is set, otherwise from old_i.
//   old_i    : word currently in memory
//   new_i    : lane-aligned store data
//   be_i     : byte enables, bit i = lane i
//   merged_o : word to write back
// -----------------------------------------------------------------------------
module be_merge (
  input  logic [31:0] old_i,
  input  logic [31:0] new_i,
  input  logic [3:0]  be_i,
  output logic [31:0] merged_o
);

  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign merged_o[8*i +: 8] = be_i[i] ? new_i[8*i +: 8] : old_i[8*i +: 8];
  end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares the single-port data_memory between the load/store unit (port 0) and
// the debug/DMA port (port 1). One transaction at a time, req/gnt/done
// handshake, round-robin only when both request in the same IDLE cycle.
// Sub-word stores are done as read-modify-write.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : requester ports and memory bus (slave modport)
// -----------------------------------------------------------------------------
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  dmem_arbiter_if.slave bus
);

  state_e       state_q, state_d;
  logic         last_q;
  logic         owner_q;
  logic         we_q;
  logic [N-1:0] addr_q;
  logic [W-1:0] wd_q;
  logic [3:0]   be_q;
  logic [W-1:0] data_q;
  logic [W-1:0] p0_rd_q, p0_rd_d;
  logic [W-1:0] p1_rd_q, p1_rd_d;
  logic [N-1:0] mem_a_q, mem_a_d;
  logic [W-1:0] mem_wd_q, mem_wd_d;

  logic         grant_v;
  logic         grant_id;
  logic         sel_we;
  logic [N-1:0] sel_addr;
  logic [W-1:0] sel_wd;
  logic [3:0]   sel_be;
  logic [W-1:0] merged;
  logic         resp;

  // Arbitration: a lone requester always wins; on conflict the port that
  // did not win last time goes. Grants are suppressed while in reset.
  always_comb begin
    grant_v  = 1'b0;
    grant_id = 1'b0;
    if (rst_n && state_q == IDLE) begin
      if (bus.p0_req && bus.p1_req) begin
        grant_v  = 1'b1;
        grant_id = ~last_q;
      end else if (bus.p0_req) begin
        grant_v  = 1'b1;
        grant_id = 1'b0;
      end else if (bus.p1_req) begin
        grant_v  = 1'b1;
        grant_id = 1'b1;
      end
    end
  end

  assign sel_we   = grant_id ? bus.p1_we   : bus.p0_we;
  assign sel_addr = grant_id ? bus.p1_addr : bus.p0_addr;
  assign sel_wd   = grant_id ? bus.p1_wd   : bus.p0_wd;
  assign sel_be   = grant_id ? bus.p1_be   : bus.p0_be;

  assign bus.p0_gnt = grant_v & ~grant_id;
  assign bus.p1_gnt = grant_v &  grant_id;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant_v) state_d = first_state(sel_we, sel_be);
      RD:      state_d = we_q ? WR : RESP;
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  be_merge u_be_merge (
    .old_i    (bus.mem_RD),
    .new_i    (wd_q),
    .be_i     (be_q),
    .merged_o (merged)
  );

  // Memory bus is only driven with live values in RD/WR; otherwise it holds
  // whatever it last showed so the memory inputs stay quiet.
  assign mem_a_d    = (state_q == RD || state_q == WR) ? addr_q : mem_a_q;
  assign mem_wd_d   = (state_q == WR) ? wd_q : mem_wd_q;
  assign bus.mem_A  = mem_a_d;
  assign bus.mem_WD = mem_wd_d;
  assign bus.mem_WE = (state_q == WR);

  assign resp        = (state_q == RESP);
  assign bus.p0_done = resp & ~owner_q;
  assign bus.p1_done = resp &  owner_q;

  // Load data is presented during RESP and then held until the next load
  // completes on that port.
  assign p0_rd_d    = (resp && !owner_q && !we_q) ? data_q : p0_rd_q;
  assign p1_rd_d    = (resp &&  owner_q && !we_q) ? data_q : p1_rd_q;
  assign bus.p0_rd  = p0_rd_d;
  assign bus.p1_rd  = p1_rd_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wd_q     <= '0;
      be_q     <= '0;
      data_q   <= '0;
      p0_rd_q  <= '0;
      p1_rd_q  <= '0;
      mem_a_q  <= '0;
      mem_wd_q <= '0;
    end else begin
      state_q  <= state_d;
      p0_rd_q  <= p0_rd_d;
      p1_rd_q  <= p1_rd_d;
      mem_a_q  <= mem_a_d;
      mem_wd_q <= mem_wd_d;
      if (grant_v) begin
        owner_q <= grant_id;
        last_q  <= grant_id;
        we_q    <= sel_we;
        addr_q  <= sel_addr;
        wd_q    <= sel_wd;
        be_q    <= sel_be;
      end
      // RD serves both loads and the read half of a partial store; the
      // merged word replaces wd_q so WR simply writes wd_q.
      if (state_q == RD) begin
        if (we_q) wd_q   <= merged;
        else      data_q <= bus.mem_RD;
      end
    end
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port data_memory (combinational read, clocked write, word-addressed) between two requesters. Port 0 is the core load/store unit and port 1 is the debug/DMA port. Each request is a one-transaction req/gnt/done handshake. Sub-word stores are executed as a read-modify-write driven by byte enables. The block sits between the requesters and data_memory, and is the only driver of the memory's A/WD/WE.

Parameters:
N, 8, word-address width (matches data_memory A)
W, 32, data width; fixed at 32 (4 byte lanes)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
p0_req  in  1  port 0 request; held with its payload until p0_gnt
p0_we  in  1  port 0: 1=store, 0=load
p0_addr  in  N  port 0 word address
p0_wd  in  32  port 0 store data, lane-aligned
p0_be  in  4  port 0 byte enables (bit i = byte lane i); ignored for loads
p0_gnt  out  1  port 0 accepted, one-cycle pulse
p0_done  out  1  port 0 transaction complete, one-cycle pulse
p0_rd  out  32  port 0 load data, valid with p0_done
p1_req/p1_we/p1_addr/p1_wd/p1_be/p1_gnt/p1_done/p1_rd  same as port 0, for port 1
mem_A  out  N  to data_memory A
mem_WD  out  32  to data_memory WD
mem_WE  out  1  to data_memory WE
mem_RD  in  32  from data_memory RD

Behaviour:
- Reset (async): state=IDLE, last_grant=1 (port 0 wins the first conflict), all gnt/done=0, p0_rd=p1_rd=0, mem_WE=0, mem_A=0, mem_WD=0, all capture registers=0.
- States: IDLE, RD, WR, RESP.
- IDLE:
  - If exactly one req is high, that port wins. If both are high, the port != last_grant wins.
  - Winner's gnt=1, combinational, in this cycle only.
  - On the edge: capture we, addr, wd, be and the owner ID; update last_grant=owner.
  - Next state: load or partial store (be not 1111 and not 0000) -> RD; full store (be=1111) -> WR; store with be=0000 -> RESP (no memory write).
  - No req -> stay in IDLE.
- RD: mem_A=addr_q, mem_WE=0.
  - Load: data_q <= mem_RD, next state RESP.
  - Partial store: wd_q <= merge(mem_RD, wd_q, be_q), next state WR. merge takes lane i from wd_q when be_q[i]=1, otherwise from mem_RD.
- WR: mem_A=addr_q, mem_WD=wd_q, mem_WE=1 for exactly this cycle; the memory writes on the edge. Next state RESP.
- RESP: owner's done=1; owner's rd=data_q for loads, rd unchanged for stores. Next state IDLE.
- Outside RD/WR: mem_WE=0 and mem_A/mem_WD hold their last registered values.
- Latency, gnt at cycle T: load done at T+2; full store done at T+2 (write at the T+1 edge); partial store done at T+3; be=0000 store done at T+1.
- Throughput: a new grant is possible in the cycle after RESP. Max one transaction per 3 cycles (4 for partial stores).
- A req asserted while not IDLE gets no gnt until IDLE; requesters keep req high and must not drop it before gnt.
- A req held high after gnt is treated as a new request at the next IDLE. Requesters deassert req in the cycle after gnt.
- Round-robin only applies on conflict. A lone requester is always granted, whatever last_grant is.
- rst_n low mid-transaction: immediate return to IDLE, mem_WE drops asynchronously, no done is issued, and a pending partial write is abandoned (memory is untouched unless the WR edge already occurred).
- Address is used as given; no wrap or bounds logic (data_memory ignores bits above N).

Decomposition:
- Shared header dmem_arb_defs.vh: state encodings (IDLE=2'd0, RD=2'd1, WR=2'd2, RESP=2'd3), BE_FULL=4'b1111, BE_NONE=4'b0000.
- One combinational sub-module: be_merge (inputs old[31:0], new[31:0], be[3:0]; output merged[31:0]), reused by future sub-word load/store logic.

Test Plan:
- p0 full store at addr 22, wd=2B345FD4, be=1111 -> p0_gnt at T, mem_WE=1 only in T+1, p0_done at T+2; a later p0 load at 22 returns p0_rd=2B345FD4 with p0_done two cycles after its gnt.
- Partial store at addr 22 over 2B345FD4 with wd=A391FFC3, be=0011 -> exactly one mem_WE cycle, done at T+3; a subsequent load at 22 reads 2B34FFC3.
- p0 and p1 both request from reset with the same timing (p0 load addr 2, p1 load addr 22) -> p0 granted first. The next conflict goes to p1, then p0 again, alternating.
- Store with be=0000, wd=A391FFC3 at addr 2 -> done at T+1, mem_WE never asserted, addr 2 contents unchanged.
- p1 request arrives during a p0 partial store -> p1_gnt held off until IDLE (cycle after p0_done), then granted; p1 payload is sampled only at its gnt.
- rst_n pulsed low during RD of a partial store to addr 22 -> mem_WE stays 0, no done, all outputs return to reset values, and a later load at 22 returns the old value.
